// File: rtl/osc_phase_accum.sv
// osc_phase_accum
//    Per-slot phase accumulator bank. A time-multiplexed slot index {vx, ox, sub}
//    and a 24-bit phase increment arrive every clock. On each sub-step-0 clock the
//    addressed slot's 32-bit phase is updated, with key-sync resets (armed by
//    key_on) and hard sync to oscillator 0 of the same voice taking precedence
//    over the plain add.
//
// Ports
//    sCLK_XVXOSC    in   1                    clock
//    reset_data_N   in   1                    synchronous active-low reset
//    xxxx           in   V_WIDTH+E_WIDTH      slot index {vx, ox, sub}
//    osc_pitch_val  in   24                   phase increment for {vx, ox}
//    key_on         in   1                    key-sync request pulse
//    key_on_voice   in   V_WIDTH              voice receiving key_on
//    keysync_en     in   1                    global key-sync enable
//    sync_en        in   V_OSC                per-oscillator hard-sync enable (bit 0 unused)
//    phase_out      out  32                   updated phase of the tagged slot
//    phase_slot     out  V_WIDTH+O_WIDTH      {vx, ox} of phase_out
//    phase_valid    out  1                    strobe qualifying phase_out/phase_slot/wrap
//    wrap           out  1                    carry-out of the producing update
module osc_phase_accum #(
   parameter int VOICES   = 8,
   parameter int V_OSC    = 4,
   parameter int V_WIDTH  = 3,
   parameter int O_WIDTH  = 2,
   parameter int OE_WIDTH = 1,
   parameter int E_WIDTH  = O_WIDTH + OE_WIDTH
) (
   input  logic                         sCLK_XVXOSC,
   input  logic                         reset_data_N,
   input  logic [V_WIDTH+E_WIDTH-1:0]   xxxx,
   input  logic [23:0]                  osc_pitch_val,
   input  logic                         key_on,
   input  logic [V_WIDTH-1:0]           key_on_voice,
   input  logic                         keysync_en,
   input  logic [V_OSC-1:0]             sync_en,
   output logic [31:0]                  phase_out,
   output logic [V_WIDTH+O_WIDTH-1:0]   phase_slot,
   output logic                         phase_valid,
   output logic                         wrap
);

   localparam int SLOTS = VOICES * V_OSC;
   localparam int SW    = V_WIDTH + O_WIDTH;

   logic [31:0]         phase_r [SLOTS];
   logic [SLOTS-1:0]    pend_r;
   logic [VOICES-1:0]   wrap0_r;

   logic [V_WIDTH-1:0]  vx_s;
   logic [O_WIDTH-1:0]  ox_s;
   logic [OE_WIDTH-1:0] sub_s;
   logic [SW-1:0]       slot_s;
   logic                upd_s;
   logic                key_set_s;
   logic [32:0]         sum_s;
   logic [31:0]         new_phase_s;
   logic                new_wrap_s;
   logic [SLOTS-1:0]    pend_nxt_s;

   // Slot index field decode.
   always_comb begin
      vx_s      = xxxx[V_WIDTH+E_WIDTH-1 -: V_WIDTH];
      ox_s      = xxxx[E_WIDTH-1 -: O_WIDTH];
      sub_s     = xxxx[OE_WIDTH-1:0];
      slot_s    = {vx_s, ox_s};
      upd_s     = (sub_s == {OE_WIDTH{1'b0}});
      key_set_s = key_on & keysync_en;
   end

   // New phase for the addressed slot: key-sync reset, then hard sync, then add.
   always_comb begin
      sum_s = {1'b0, phase_r[slot_s]} + {9'd0, osc_pitch_val};
      if (pend_r[slot_s]) begin
         new_phase_s = 32'd0;
         new_wrap_s  = 1'b0;
      end else if ((ox_s != {O_WIDTH{1'b0}}) && sync_en[ox_s] && wrap0_r[vx_s]) begin
         new_phase_s = 32'd0;
         new_wrap_s  = 1'b0;
      end else begin
         new_phase_s = sum_s[31:0];
         new_wrap_s  = sum_s[32];
      end
   end

   // Pending key-sync bits: a key_on set beats the clear from a same-clock update.
   always_comb begin
      pend_nxt_s = pend_r;
      for (int s = 0; s < SLOTS; s++) begin
         if (key_set_s && (key_on_voice == V_WIDTH'(s / V_OSC))) begin
            pend_nxt_s[s] = 1'b1;
         end else if (upd_s && (slot_s == SW'(s))) begin
            pend_nxt_s[s] = 1'b0;
         end else begin
            pend_nxt_s[s] = pend_r[s];
         end
      end
   end

   // Phase storage, pending bits and oscillator-0 wrap history.
   always_ff @(posedge sCLK_XVXOSC) begin
      if (!reset_data_N) begin
         for (int s = 0; s < SLOTS; s++) begin
            phase_r[s] <= 32'd0;
         end
         pend_r  <= {SLOTS{1'b0}};
         wrap0_r <= {VOICES{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
         if (upd_s) begin
            phase_r[slot_s] <= new_phase_s;
            if (ox_s == {O_WIDTH{1'b0}}) begin
               wrap0_r[vx_s] <= new_wrap_s;
            end
         end
      end
   end

   // Registered outputs; data outputs hold between visits, valid strobes once per visit.
   always_ff @(posedge sCLK_XVXOSC) begin
      if (!reset_data_N) begin
         phase_out   <= 32'd0;
         phase_slot  <= {SW{1'b0}};
         wrap        <= 1'b0;
         phase_valid <= 1'b0;
      end else begin
         phase_valid <= upd_s;
         if (upd_s) begin
            phase_out  <= new_phase_s;
            phase_slot <= slot_s;
            wrap       <= new_wrap_s;
         end
      end
   end

endmodule
